// File: rtl/vga_sync_receiver_if.sv
// vga_sync_receiver_if: VGA sample inputs and framed pixel/lock/statistics outputs of vga_sync_receiver.
interface vga_sync_receiver_if;
    logic        iPixEn;
    logic        iVgaHs;
    logic        iVgaVs;
    logic [9:0]  iRed;
    logic [9:0]  iGreen;
    logic [9:0]  iBlue;
    logic [9:0]  oRed;
    logic [9:0]  oGreen;
    logic [9:0]  oBlue;
    logic        oValid;
    logic        oSof;
    logic        oEol;
    logic [12:0] oX;
    logic [12:0] oY;
    logic        oLocked;
    logic [12:0] oHTotal;
    logic [12:0] oVTotal;
    logic [7:0]  oErrCount;
    modport master (
        output iPixEn, iVgaHs, iVgaVs, iRed, iGreen, iBlue,
        input  oRed, oGreen, oBlue, oValid, oSof, oEol, oX, oY, oLocked, oHTotal, oVTotal, oErrCount
    );
    modport slave (
        input  iPixEn, iVgaHs, iVgaVs, iRed, iGreen, iBlue,
        output oRed, oGreen, oBlue, oValid, oSof, oEol, oX, oY, oLocked, oHTotal, oVTotal, oErrCount
    );
endinterface

// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver: VGA timing checker with lock FSM and framed pixel capture.
// Define VGA_RX_STATS_EN to build the line/frame length and error-count statistics.
module vga_sync_receiver #(
    parameter int H_SYNC_CYC   = 96,
    parameter int H_SYNC_BACK  = 48,
    parameter int H_SYNC_ACT   = 640,
    parameter int H_SYNC_TOTAL = 800,
    parameter int V_SYNC_CYC   = 2,
    parameter int V_SYNC_BACK  = 33,
    parameter int V_SYNC_ACT   = 480,
    parameter int V_SYNC_TOTAL = 525,
    parameter int LOCK_FRAMES  = 2
) (
    input  logic               clock_50,
    input  logic               reset,
    vga_sync_receiver_if.slave vga
);
    localparam int H_START = H_SYNC_CYC + H_SYNC_BACK;
    localparam int V_START = V_SYNC_CYC + V_SYNC_BACK;
    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;
    state_t      state;
    logic        hs_prev, vs_prev, h_armed, line_err_seen, out_en;
    logic [3:0]  good_cnt;
    logic [12:0] hcnt, vcnt, h_nxt, v_nxt;
    logic        hs_fall, vs_fall, line_err, frame_len_err, frame_bad, lost, to_search;
    logic        active, sof, eol, emit;
    always_comb begin
        hs_fall       = vga.iPixEn & hs_prev & ~vga.iVgaHs;
        vs_fall       = vga.iPixEn & vs_prev & ~vga.iVgaVs;
        line_err      = hs_fall & h_armed & (hcnt + 13'd1 != 13'(H_SYNC_TOTAL));
        frame_len_err = vs_fall & (state != SEARCH) & (vcnt + 13'd1 != 13'(V_SYNC_TOTAL));
        frame_bad     = frame_len_err | line_err_seen | line_err;
        lost          = line_err | (vs_fall & frame_bad);
        to_search     = (state == LOCKED) & lost;
        h_nxt         = hs_fall ? 13'd0 : (&hcnt ? hcnt : hcnt + 13'd1);
        v_nxt         = vs_fall ? 13'd0 : hs_fall ? (&vcnt ? vcnt : vcnt + 13'd1) : vcnt;
        active        = h_nxt >= 13'(H_START) && h_nxt < 13'(H_START + H_SYNC_ACT) &&
                        v_nxt >= 13'(V_START) && v_nxt < 13'(V_START + V_SYNC_ACT);
        sof           = h_nxt == 13'(H_START) && v_nxt == 13'(V_START);
        eol           = h_nxt == 13'(H_START + H_SYNC_ACT - 1);
        // After a relock the stream only restarts on a frame's first pixel
        emit          = vga.iPixEn & (state == LOCKED) & ~lost & active & (out_en | sof);
    end
    always_ff @(posedge clock_50) begin
        if (reset) begin
            state         <= SEARCH;
            good_cnt      <= '0;
            hs_prev       <= 1'b1;
            vs_prev       <= 1'b1;
            hcnt          <= '0;
            vcnt          <= '0;
            h_armed       <= 1'b0;
            line_err_seen <= 1'b0;
            out_en        <= 1'b0;
            vga.oValid    <= 1'b0;
            vga.oSof      <= 1'b0;
            vga.oEol      <= 1'b0;
            vga.oRed      <= '0;
            vga.oGreen    <= '0;
            vga.oBlue     <= '0;
            vga.oX        <= '0;
            vga.oY        <= '0;
            vga.oLocked   <= 1'b0;
        end else begin
            vga.oValid <= emit;
            vga.oSof   <= emit & sof;
            vga.oEol   <= emit & eol;
            if (emit) begin
                vga.oRed   <= vga.iRed;
                vga.oGreen <= vga.iGreen;
                vga.oBlue  <= vga.iBlue;
                vga.oX     <= h_nxt - 13'(H_START);
                vga.oY     <= v_nxt - 13'(V_START);
            end
            if (vga.iPixEn) begin
                hs_prev       <= vga.iVgaHs;
                vs_prev       <= vga.iVgaVs;
                hcnt          <= h_nxt;
                vcnt          <= v_nxt;
                h_armed       <= ~to_search & (h_armed | hs_fall);
                line_err_seen <= vs_fall ? 1'b0 : line_err_seen | line_err;
                out_en        <= ~to_search & (out_en | emit);
                case (state)
                    SEARCH: if (vs_fall) begin
                        state    <= CHECK;
                        good_cnt <= '0;
                    end
                    CHECK: if (vs_fall) begin
                        if (frame_bad) good_cnt <= '0;
                        else if ({1'b0, good_cnt} + 5'd1 >= 5'(LOCK_FRAMES)) begin
                            state       <= LOCKED;
                            good_cnt    <= '0;
                            vga.oLocked <= 1'b1;
                        end else good_cnt <= good_cnt + 4'd1;
                    end
                    LOCKED: if (lost) begin
                        state       <= SEARCH;
                        vga.oLocked <= 1'b0;
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end
`ifdef VGA_RX_STATS_EN
    logic [12:0] h_total, v_total;
    logic [7:0]  err_count;
    logic [8:0]  err_sum;
    assign err_sum = {1'b0, err_count} + 9'(line_err) + 9'(frame_len_err);
    always_ff @(posedge clock_50) begin
        if (reset) begin
            h_total   <= '0;
            v_total   <= '0;
            err_count <= '0;
        end else begin
            if (hs_fall) h_total <= hcnt + 13'd1;
            if (vs_fall) v_total <= vcnt + 13'd1;
            err_count <= err_sum > 9'd255 ? 8'd255 : err_sum[7:0];
        end
    end
    assign vga.oHTotal   = h_total;
    assign vga.oVTotal   = v_total;
    assign vga.oErrCount = err_count;
`else
    assign vga.oHTotal   = '0;
    assign vga.oVTotal   = '0;
    assign vga.oErrCount = '0;
`endif
endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb_vga_sync_receiver: directed frame sequence on scaled timing (28x12 totals, 16x6 active).
module tb_vga_sync_receiver;
    localparam int HC = 4, HB = 4, HA = 16, HT = 28;
    localparam int VC = 2, VB = 2, VA = 6, VT = 12;
    typedef struct packed {
        logic [9:0]  r, g, b;
        logic [12:0] x, y;
        logic        sof, eol;
    } pix_t;
    logic clock_50 = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    pix_t sb[$];
    vga_sync_receiver_if vga ();
    vga_sync_receiver #(
        .H_SYNC_CYC(HC), .H_SYNC_BACK(HB), .H_SYNC_ACT(HA), .H_SYNC_TOTAL(HT),
        .V_SYNC_CYC(VC), .V_SYNC_BACK(VB), .V_SYNC_ACT(VA), .V_SYNC_TOTAL(VT),
        .LOCK_FRAMES(2)
    ) dut (
        .clock_50(clock_50),
        .reset(reset),
        .vga(vga.slave)
    );
    always #5 clock_50 = ~clock_50;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_valid"}, 64'(vga.oValid), 0);
        chk({tag, "_sofeol"}, 64'({vga.oSof, vga.oEol}), 0);
        chk({tag, "_rgb"}, 64'({vga.oRed, vga.oGreen, vga.oBlue}), 0);
        chk({tag, "_xy"}, 64'({vga.oX, vga.oY}), 0);
        chk({tag, "_locked"}, 64'(vga.oLocked), 0);
        chk({tag, "_stats"}, 64'({vga.oHTotal, vga.oVTotal, vga.oErrCount}), 0);
    endtask
    task automatic chk_stats(input string tag, input int ht, input int vt, input int ec);
`ifdef VGA_RX_STATS_EN
        chk({tag, "_stats"}, 64'({vga.oHTotal, vga.oVTotal, vga.oErrCount}), 64'({13'(ht), 13'(vt), 8'(ec)}));
`else
        chk({tag, "_stats_off"}, 64'({vga.oHTotal, vga.oVTotal, vga.oErrCount}), 0);
`endif
    endtask
    // Drives one frame; lk = lock expected from the frame's VS onward.
    task automatic run_frame(input int fid, input int lines, input logic lk, input int bad_line,
                             input int rst_line, input int rst_pix,
                             output int nv, output int ns, output int ne);
        logic cur;
        int   len;
        pix_t e, got;
        cur = lk;
        nv = 0; ns = 0; ne = 0;
        for (int l = 0; l < lines; l++) begin
            len = (l == bad_line) ? HT - 1 : HT;
            for (int p = 0; p < len; p++) begin
                if (l == rst_line && p == rst_pix) begin
                    reset = 1'b1;
                    @(posedge clock_50); #1;
                    reset = 1'b0;
                    cur = 1'b0;
                    chk_zero_outputs("midreset");
                    chk("midreset_sb", 64'(sb.size()), 0);
                end
                if (bad_line >= 0 && l == bad_line + 1 && p == 0) cur = 1'b0;
                vga.iPixEn = 1'b1;
                vga.iVgaHs = (p >= HC);
                vga.iVgaVs = (l >= VC);
                vga.iRed   = 10'(p);
                vga.iGreen = 10'(l);
                vga.iBlue  = 10'(fid);
                if (cur && p >= HC + HB && p < HC + HB + HA && l >= VC + VB && l < VC + VB + VA) begin
                    e.r = 10'(p); e.g = 10'(l); e.b = 10'(fid);
                    e.x = 13'(p - HC - HB); e.y = 13'(l - VC - VB);
                    e.sof = (e.x == 0 && e.y == 0);
                    e.eol = (e.x == HA - 1);
                    sb.push_back(e);
                end
                @(posedge clock_50); #1;
                chk("valid", 64'(vga.oValid), 64'(sb.size() != 0));
                if (vga.oValid === 1'b1 && sb.size() != 0) begin
                    e = sb.pop_front();
                    got = {vga.oRed, vga.oGreen, vga.oBlue, vga.oX, vga.oY, vga.oSof, vga.oEol};
                    chk("pixel", 64'(got), 64'(e));
                end
                if (vga.oValid === 1'b1) begin
                    nv++;
                    if (vga.oSof === 1'b1) ns++;
                    if (vga.oEol === 1'b1) ne++;
                end
                chk("locked", 64'(vga.oLocked), 64'(cur));
                vga.iPixEn = 1'b0;
                @(posedge clock_50); #1;
                chk("gap_valid", 64'(vga.oValid), 0);
            end
        end
    endtask
    task automatic frame_counts(input string tag, input int nv, input int ns, input int ne,
                                input int ev, input int es, input int ee);
        chk({tag, "_nvalid"}, 64'(nv), 64'(ev));
        chk({tag, "_nsof"}, 64'(ns), 64'(es));
        chk({tag, "_neol"}, 64'(ne), 64'(ee));
    endtask
    initial begin
        int nv, ns, ne;
        vga.iPixEn = 1'b0;
        vga.iVgaHs = 1'b1;
        vga.iVgaVs = 1'b1;
        vga.iRed   = '0;
        vga.iGreen = '0;
        vga.iBlue  = '0;
        repeat (3) @(posedge clock_50);
        #1;
        reset = 1'b0;
        chk_zero_outputs("reset");
        run_frame(0, VT, 1'b0, -1, -1, -1, nv, ns, ne);
        frame_counts("f0", nv, ns, ne, 0, 0, 0);
        run_frame(1, VT, 1'b0, -1, -1, -1, nv, ns, ne);
        frame_counts("f1", nv, ns, ne, 0, 0, 0);
        run_frame(2, VT, 1'b1, -1, -1, -1, nv, ns, ne);
        frame_counts("f2", nv, ns, ne, HA * VA, 1, VA);
        run_frame(3, VT, 1'b1, -1, -1, -1, nv, ns, ne);
        frame_counts("f3", nv, ns, ne, HA * VA, 1, VA);
        chk_stats("f3", HT, VT, 0);
        run_frame(4, VT, 1'b1, 5, -1, -1, nv, ns, ne);
        frame_counts("f4_badline", nv, ns, ne, 2 * HA, 1, 2);
        chk_stats("f4", HT, VT, 1);
        run_frame(5, VT, 1'b0, -1, -1, -1, nv, ns, ne);
        frame_counts("f5", nv, ns, ne, 0, 0, 0);
        run_frame(6, VT, 1'b0, -1, -1, -1, nv, ns, ne);
        frame_counts("f6", nv, ns, ne, 0, 0, 0);
        run_frame(7, VT, 1'b1, -1, -1, -1, nv, ns, ne);
        frame_counts("f7_relock", nv, ns, ne, HA * VA, 1, VA);
        run_frame(8, VT, 1'b1, -1, 5, 12, nv, ns, ne);
        frame_counts("f8_reset", nv, ns, ne, HA + 4, 1, 1);
        run_frame(9, VT - 1, 1'b0, -1, -1, -1, nv, ns, ne);
        frame_counts("f9_short", nv, ns, ne, 0, 0, 0);
        run_frame(10, VT, 1'b0, -1, -1, -1, nv, ns, ne);
        frame_counts("f10", nv, ns, ne, 0, 0, 0);
        chk_stats("f10", HT, VT - 1, 1);
        run_frame(11, VT, 1'b0, -1, -1, -1, nv, ns, ne);
        frame_counts("f11", nv, ns, ne, 0, 0, 0);
        run_frame(12, VT, 1'b1, -1, -1, -1, nv, ns, ne);
        frame_counts("f12_lock", nv, ns, ne, HA * VA, 1, VA);
        chk_stats("f12", HT, VT, 1);
        chk("sb_empty", 64'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
